// File: rtl/gh_fifo_sync_sr.sv
// rtl/gh_fifo_sync_sr.sv - parametrised show-ahead single-clock FIFO with count, almost flags and trigger
// Optional sticky overflow/underflow flags are enabled by defining GH_FIFO_STICKY_ERR_EN.

module gh_fifo_sync_sr #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int AW        = $clog2(DEPTH),
    parameter int AF_MARGIN = 2,
    parameter int AE_MARGIN = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             srst,
    input  logic             wr,
    input  logic             rd,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             empty,
    output logic             full,
    output logic             afull,
    output logic             aempty,
    output logic [AW:0]      count,
    input  logic [AW:0]      trig_lvl,
    output logic             trig,
    output logic             ovf,
    output logic             udf
);

    generate
        if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
            $error("gh_fifo_sync_sr: DEPTH must be a power of two and >= 2");
        end
    endgenerate

    localparam int AF_LVL = DEPTH - AF_MARGIN;
    localparam int AE_LVL = AE_MARGIN;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             wa;
    logic             ra;

    // srst wins over both strobes, so nothing is accepted on a clearing edge
    assign wa = wr & ~full & ~srst;
    assign ra = rd & ~empty & ~srst;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (srst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wa) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (ra) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (wa && !ra) begin
                count <= count + (AW+1)'(1);
            end else if (ra && !wa) begin
                count <= count - (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wa) begin
            mem[wr_ptr] <= d;
        end
    end

    assign q      = mem[rd_ptr];
    assign empty  = (count == '0);
    assign full   = (32'(count) == DEPTH);
    assign afull  = (32'(count) >= AF_LVL);
    assign aempty = (32'(count) <= AE_LVL);
    assign trig   = (trig_lvl != '0) && (count >= trig_lvl);

`ifdef GH_FIFO_STICKY_ERR_EN
    logic ovf_r;
    logic udf_r;

    // Raw strobes are used so rejected attempts are recorded even when the other side was accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_r <= 1'b0;
            udf_r <= 1'b0;
        end else if (srst) begin
            ovf_r <= 1'b0;
            udf_r <= 1'b0;
        end else begin
            if (wr && full) begin
                ovf_r <= 1'b1;
            end
            if (rd && empty) begin
                udf_r <= 1'b1;
            end
        end
    end

    assign ovf = ovf_r;
    assign udf = udf_r;
`else
    assign ovf = 1'b0;
    assign udf = 1'b0;
`endif

endmodule

// File: tb/tb_gh_fifo_sync_sr.sv
// tb/tb_gh_fifo_sync_sr.sv - directed bench for gh_fifo_sync_sr with a queue-based reference model

module tb_gh_fifo_sync_sr;

    localparam int DEPTH = 16;
`ifdef GH_FIFO_STICKY_ERR_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       srst = 1'b0;
    logic       wr = 1'b0;
    logic       rd = 1'b0;
    logic [7:0] d = '0;
    logic [7:0] q;
    logic       empty, full, afull, aempty, trig, ovf, udf;
    logic [4:0] count;
    logic [4:0] trig_lvl = 5'd8;

    int n_cmp = 0;
    int n_err = 0;
    bit run = 1'b0;

    logic [7:0] mq[$];
    bit         m_ovf = 1'b0;
    bit         m_udf = 1'b0;

    gh_fifo_sync_sr dut (
        .clk(clk), .rst_n(rst_n), .srst(srst), .wr(wr), .rd(rd), .d(d), .q(q),
        .empty(empty), .full(full), .afull(afull), .aempty(aempty), .count(count),
        .trig_lvl(trig_lvl), .trig(trig), .ovf(ovf), .udf(udf)
    );

    always #5 clk = ~clk;

    // Reference: a plain queue bounded at DEPTH
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n || srst) begin
            mq.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
            bit was_full, was_empty;
            was_full  = (mq.size() == DEPTH);
            was_empty = (mq.size() == 0);
            if (STICKY && wr && was_full) m_ovf = 1'b1;
            if (STICKY && rd && was_empty) m_udf = 1'b1;
            if (rd && !was_empty) void'(mq.pop_front());
            if (wr && !was_full) mq.push_back(d);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (run) begin
            int n;
            n = mq.size();
            chk("m_count", int'(count), n);
            chk("m_empty", int'(empty), int'(n == 0));
            chk("m_full", int'(full), int'(n == DEPTH));
            chk("m_afull", int'(afull), int'(n >= DEPTH - 2));
            chk("m_aempty", int'(aempty), int'(n <= 2));
            chk("m_trig", int'(trig), int'(trig_lvl != 0 && n >= int'(trig_lvl)));
            chk("m_ovf", int'(ovf), int'(m_ovf));
            chk("m_udf", int'(udf), int'(m_udf));
            if (n != 0) chk("m_q", int'(q), int'(mq[0]));
        end
    end

    task automatic step(input logic w, input logic r, input logic [7:0] dd, input logic s);
        wr = w; rd = r; d = dd; srst = s;
        @(posedge clk);
        #1;
        wr = 1'b0; rd = 1'b0; srst = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_empty", int'(empty), 1);
        chk("rst_count", int'(count), 0);
        chk("rst_full", int'(full), 0);
        chk("rst_aempty", int'(aempty), 1);
        chk("rst_afull", int'(afull), 0);
        chk("rst_trig", int'(trig), 0);
        rst_n = 1'b1;
        run = 1'b1;

        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'b0, 8'(i), 1'b0);
            chk("fill_count", int'(count), i + 1);
            if (i == 6)  chk("trig_below", int'(trig), 0);
            if (i == 7)  chk("trig_at8", int'(trig), 1);
            if (i == 12) chk("afull_13", int'(afull), 0);
            if (i == 13) chk("afull_14", int'(afull), 1);
        end
        chk("full_16", int'(full), 1);
        step(1'b1, 1'b0, 8'hAA, 1'b0);
        chk("ovf_write_count", int'(count), 16);

        for (int i = 0; i < 16; i++) begin
            chk("drain_q", int'(q), i);
            step(1'b0, 1'b1, 8'h00, 1'b0);
            if (i == 12) chk("aempty_3", int'(aempty), 0);
            if (i == 13) chk("aempty_2", int'(aempty), 1);
        end
        chk("drain_empty", int'(empty), 1);
        step(1'b1, 1'b0, 8'h55, 1'b0);
        chk("wrap_q", int'(q), 8'h55);
        step(1'b0, 1'b1, 8'h00, 1'b0);
        chk("wrap_empty", int'(empty), 1);

        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'h10 + 8'(i), 1'b0);
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b1, 8'h77, 1'b0);
            chk("simul_count", int'(count), 5);
        end
        for (int i = 0; i < 11; i++) step(1'b1, 1'b0, 8'hC0 + 8'(i), 1'b0);
        chk("simul_full", int'(full), 1);
        step(1'b1, 1'b1, 8'h99, 1'b0);
        chk("full_wrrd_count", int'(count), 15);
        for (int i = 0; i < 15; i++) step(1'b0, 1'b1, 8'h00, 1'b0);
        chk("pre_empty", int'(empty), 1);
        step(1'b1, 1'b1, 8'h3C, 1'b0);
        chk("empty_wrrd_count", int'(count), 1);
        chk("empty_wrrd_q", int'(q), 8'h3C);
        step(1'b0, 1'b1, 8'h00, 1'b0);

        for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 8'h20 + 8'(i), 1'b0);
        chk("srst_pre", int'(count), 9);
        step(1'b1, 1'b0, 8'hEE, 1'b1);
        chk("srst_count", int'(count), 0);
        chk("srst_empty", int'(empty), 1);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        chk("srst_discard", int'(count), 0);

        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 8'h40 + 8'(i), 1'b0);
        trig_lvl = 5'd16; #1;
        chk("trig_lvl16", int'(trig), 1);
        trig_lvl = 5'd17; #1;
        chk("trig_lvl17", int'(trig), 0);
        trig_lvl = 5'd0; #1;
        chk("trig_lvl0", int'(trig), 0);
        trig_lvl = 5'd8;
        step(1'b0, 1'b0, 8'h00, 1'b0);

        step(1'b1, 1'b0, 8'hAB, 1'b0);
        chk("ovf_set", int'(ovf), int'(STICKY));
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'h00, 1'b0);
        chk("ovf_hold", int'(ovf), int'(STICKY));
        chk("ovf_q", int'(q), 8'h43);
        for (int i = 0; i < 13; i++) step(1'b0, 1'b1, 8'h00, 1'b0);
        chk("udf_pre", int'(udf), 0);
        step(1'b0, 1'b1, 8'h00, 1'b0);
        chk("udf_set", int'(udf), int'(STICKY));
        step(1'b0, 1'b0, 8'h00, 1'b1);
        chk("srst_ovf", int'(ovf), 0);
        chk("srst_udf", int'(udf), 0);

        for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 8'h60 + 8'(i), 1'b0);
        chk("async_pre", int'(count), 7);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_count", int'(count), 0);
        chk("async_empty", int'(empty), 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1'b0, 1'b0, 8'h00, 1'b0);
        chk("async_after", int'(count), 0);

        run = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
